bird_physics: RTL

//  Parametrised vertical-physics engine for the player sprite; next generation of the bird datapath.

---
 rtl/bird_physics_pkg.sv | 27 ++
 rtl/bird_step.sv | 56 +++++
 rtl/bird_physics.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bird_physics_pkg.sv
// Shared types and default tuning for the bird vertical-physics engine.
// State encodings match the state_out bus seen by the draw FSM.
package bird_physics_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FLY  = 2'b01,
        ST_DEAD = 2'b10
    } bird_state_t;

    localparam int DEF_Y_W         = 8;
    localparam int DEF_FRAC_W      = 4;
    localparam int DEF_Y_START     = 64;
    localparam int DEF_Y_MIN       = 0;
    localparam int DEF_Y_MAX       = 108;
    localparam int DEF_GRAVITY     = 4;
    localparam int DEF_VY_JUMP     = -40;
    localparam int DEF_VY_MAX      = 48;
    localparam int DEF_DEAD_TICKS  = 64;
    localparam int DEF_FLOOR_KILLS = 1;

    // Width of a counter that must reach n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bird_step.sv
// One physics integration step: velocity update, position sum and ceiling/floor clamp.
// Purely combinational so several birds could share the same update rule.
module bird_step
    import bird_physics_pkg::*;
#(
    parameter int Y_W     = DEF_Y_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int Y_MIN   = DEF_Y_MIN,
    parameter int Y_MAX   = DEF_Y_MAX,
    parameter int GRAVITY = DEF_GRAVITY,
    parameter int VY_JUMP = DEF_VY_JUMP,
    parameter int VY_MAX  = DEF_VY_MAX
) (
    input  logic [Y_W+FRAC_W-1:0]      pos,
    input  logic signed [Y_W+FRAC_W:0] vy,
    input  logic                       jump_now,
    output logic [Y_W+FRAC_W-1:0]      pos_next,
    output logic signed [Y_W+FRAC_W:0] vy_next,
    output logic                       hit_ceiling,
    output logic                       hit_floor
);
    localparam int POS_W = Y_W + FRAC_W;
    localparam int VY_W  = POS_W + 1;
    localparam int SUM_W = POS_W + 2;

    localparam logic signed [SUM_W-1:0] POS_MIN_S = SUM_W'(Y_MIN * (2 ** FRAC_W));
    localparam logic signed [SUM_W-1:0] POS_MAX_S = SUM_W'(Y_MAX * (2 ** FRAC_W));
    localparam logic signed [SUM_W-1:0] GRAV_S    = SUM_W'(GRAVITY);
    localparam logic signed [SUM_W-1:0] JUMP_S    = SUM_W'(VY_JUMP);
    localparam logic signed [SUM_W-1:0] VMAX_S    = SUM_W'(VY_MAX);

    logic signed [SUM_W-1:0] vy_grav;
    logic signed [SUM_W-1:0] vy_acc;
    logic signed [SUM_W-1:0] pos_sum;

    always_comb begin
        vy_grav     = SUM_W'(vy) + GRAV_S;
        vy_acc      = jump_now ? JUMP_S : ((vy_grav > VMAX_S) ? VMAX_S : vy_grav);
        // Position is unsigned; two guard bits keep the sum from wrapping either way.
        pos_sum     = $signed({2'b00, pos}) + vy_acc;
        hit_ceiling = 1'b0;
        hit_floor   = 1'b0;
        pos_next    = pos_sum[POS_W-1:0];
        vy_next     = vy_acc[VY_W-1:0];
        if (pos_sum < POS_MIN_S) begin
            hit_ceiling = 1'b1;
            pos_next    = POS_MIN_S[POS_W-1:0];
            vy_next     = '0;
        end else if (pos_sum >= POS_MAX_S) begin
            hit_floor = 1'b1;
            pos_next  = POS_MAX_S[POS_W-1:0];
            vy_next   = '0;
        end
    end

endmodule

// File: rtl/bird_physics.sv
// Vertical physics engine for the player sprite: fixed-point position/velocity,
// per-tick integration and the IDLE/FLY/DEAD life cycle with timed respawn.
module bird_physics
    import bird_physics_pkg::*;
#(
    parameter int Y_W         = DEF_Y_W,
    parameter int FRAC_W      = DEF_FRAC_W,
    parameter int Y_START     = DEF_Y_START,
    parameter int Y_MIN       = DEF_Y_MIN,
    parameter int Y_MAX       = DEF_Y_MAX,
    parameter int GRAVITY     = DEF_GRAVITY,
    parameter int VY_JUMP     = DEF_VY_JUMP,
    parameter int VY_MAX      = DEF_VY_MAX,
    parameter int DEAD_TICKS  = DEF_DEAD_TICKS,
    parameter int FLOOR_KILLS = DEF_FLOOR_KILLS
) (
    input  logic                       clk,
    input  logic                       Clear_b,
    input  logic                       tick,
    input  logic                       start,
    input  logic                       jump,
    input  logic                       collision,
    output logic [Y_W-1:0]             y_out,
    output logic signed [Y_W+FRAC_W:0] vy_out,
    output logic [1:0]                 state_out,
    output logic                       grounded,
    output logic                       dead
);
    localparam int POS_W = Y_W + FRAC_W;
    localparam int CNT_W = cnt_width(DEAD_TICKS);

    localparam logic [POS_W-1:0] POS_START = POS_W'(Y_START * (2 ** FRAC_W));
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEAD_TICKS - 1);

    bird_state_t               state_reg;
    logic [POS_W-1:0]          pos_reg;
    logic signed [POS_W:0]     vy_reg;
    logic [CNT_W-1:0]          cnt_reg;
    logic                      pending_reg;
    logic                      grounded_reg;
    logic                      dead_reg;

    logic [POS_W-1:0]          pos_next;
    logic signed [POS_W:0]     vy_next;
    logic                      hit_ceiling;
    logic                      hit_floor;

    // A jump arriving on the tick cycle itself is honoured by that tick.
    bird_step #(
        .Y_W     (Y_W),
        .FRAC_W  (FRAC_W),
        .Y_MIN   (Y_MIN),
        .Y_MAX   (Y_MAX),
        .GRAVITY (GRAVITY),
        .VY_JUMP (VY_JUMP),
        .VY_MAX  (VY_MAX)
    ) u_step (
        .pos         (pos_reg),
        .vy          (vy_reg),
        .jump_now    (pending_reg | jump),
        .pos_next    (pos_next),
        .vy_next     (vy_next),
        .hit_ceiling (hit_ceiling),
        .hit_floor   (hit_floor)
    );

    always_ff @(posedge clk) begin
        if (!Clear_b) begin
            state_reg    <= ST_IDLE;
            pos_reg      <= POS_START;
            vy_reg       <= '0;
            cnt_reg      <= '0;
            pending_reg  <= 1'b0;
            grounded_reg <= 1'b0;
            dead_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    pos_reg      <= POS_START;
                    vy_reg       <= '0;
                    cnt_reg      <= '0;
                    grounded_reg <= 1'b0;
                    dead_reg     <= 1'b0;
                    if (start || jump) begin
                        state_reg   <= ST_FLY;
                        pending_reg <= jump;
                    end
                end
                ST_FLY: begin
                    if (collision) begin
                        // Freeze in place; the hit wins over any jump or clamp this cycle.
                        state_reg   <= ST_DEAD;
                        vy_reg      <= '0;
                        pending_reg <= 1'b0;
                        cnt_reg     <= '0;
                        dead_reg    <= 1'b1;
                    end else if (tick) begin
                        pos_reg      <= pos_next;
                        vy_reg       <= vy_next;
                        pending_reg  <= 1'b0;
                        grounded_reg <= hit_floor;
                        if (hit_floor && (FLOOR_KILLS != 0)) begin
                            state_reg <= ST_DEAD;
                            cnt_reg   <= '0;
                            dead_reg  <= 1'b1;
                        end
                    end else if (jump) begin
                        pending_reg <= 1'b1;
                    end
                end
                ST_DEAD: begin
                    pending_reg <= 1'b0;
                    if (tick) begin
                        if (cnt_reg == CNT_LAST) begin
                            state_reg    <= ST_IDLE;
                            pos_reg      <= POS_START;
                            vy_reg       <= '0;
                            grounded_reg <= 1'b0;
                            dead_reg     <= 1'b0;
                            cnt_reg      <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    dead_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign y_out     = pos_reg[POS_W-1:FRAC_W];
    assign vy_out    = vy_reg;
    assign state_out = state_reg;
    assign grounded  = grounded_reg;
    assign dead      = dead_reg;

    logic unused_flags;
    assign unused_flags = hit_ceiling;

endmodule
